// File: rtl/brew_timer_pkg.sv
// Shared types and constants for the brew countdown timer: FSM states,
// the BCD digit type, active-low 7-segment patterns and small helpers.
package brew_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int SCAN_W = 2;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Saturate a preset nibble to the largest legal value for its position
    function automatic bcd_t bcd_clamp(input bcd_t d, input bcd_t max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/brew_countdown_timer_sync.sv
// level_edge_sync: brings a slow divided clock level into the clk domain
// through SYNC_STAGES flops, then emits a one-clk tick on its rising edge.
module level_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level_in,
    output logic rise_tick
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_stages
            $error("level_edge_sync: SYNC_STAGES must be at least 2");
        end
    endgenerate

    // Shift the level through the chain and remember the last synced value
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], level_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and edge registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_tick = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/brew_countdown_timer.sv
// brew_countdown_timer: BCD mm:ss countdown with a multiplexed active-low
// 4-digit display. The divided clocks are sampled as data only.
// Optional build macro BREW_BLINK_EN: blink the display in FINISHED.
module brew_countdown_timer
    import brew_timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_DIV   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1hz_in,
    input  logic       clk_scan_in,
    input  logic       start,
    input  logic       pause,
    input  logic       cancel,
    input  logic [3:0] load_mt,
    input  logic [3:0] load_mu,
    input  logic [3:0] load_st,
    input  logic [3:0] load_su,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    state_t              state_q, state_d;
    bcd_t                mt_q, mu_q, st_q, su_q;
    bcd_t                mt_d, mu_d, st_d, su_d;
    logic                done_q, done_d;
    logic [SCAN_W-1:0]   idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic                sec_tick, scan_tick;
    bcd_t                ld_mt, ld_mu, ld_st, ld_su;
    bcd_t                sel_digit;
    logic [3:0]          an_scan;

    generate
        if (BLINK_DIV < 1) begin : g_bad_blink
            $error("brew_countdown_timer: BLINK_DIV must be at least 1");
        end
    endgenerate

    level_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_in  (clk_1hz_in),
        .rise_tick (sec_tick)
    );

    level_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .level_in  (clk_scan_in),
        .rise_tick (scan_tick)
    );

    assign ld_mt = bcd_clamp(load_mt, 4'd9);
    assign ld_mu = bcd_clamp(load_mu, 4'd9);
    assign ld_st = bcd_clamp(load_st, 4'd5);
    assign ld_su = bcd_clamp(load_su, 4'd9);

    // Control FSM and BCD countdown; priority cancel > start > pause > tick
    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        st_d    = st_q;
        su_d    = su_q;
        done_d  = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
            mt_d    = '0;
            mu_d    = '0;
            st_d    = '0;
            su_d    = '0;
        end else if (start && (state_q == ST_IDLE || state_q == ST_FINISHED)) begin
            mt_d = ld_mt;
            mu_d = ld_mu;
            st_d = ld_st;
            su_d = ld_su;
            if ({ld_mt, ld_mu, ld_st, ld_su} == 16'h0000) begin
                state_d = ST_FINISHED;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (pause && state_q == ST_RUN) begin
            state_d = ST_PAUSED;
        end else if (pause && state_q == ST_PAUSED) begin
            state_d = ST_RUN;
        end else if (sec_tick && state_q == ST_RUN) begin
            if (su_q != 4'd0) begin
                su_d = su_q - 4'd1;
            end else begin
                su_d = 4'd9;
                if (st_q != 4'd0) begin
                    st_d = st_q - 4'd1;
                end else begin
                    st_d = 4'd5;
                    if (mu_q != 4'd0) begin
                        mu_d = mu_q - 4'd1;
                    end else begin
                        mu_d = 4'd9;
                        mt_d = mt_q - 4'd1;
                    end
                end
            end
            if ({mt_d, mu_d, st_d, su_d} == 16'h0000) begin
                state_d = ST_FINISHED;
                done_d  = 1'b1;
            end
        end
    end

    // Digit scan index and registered segment decode of the selected digit
    always_comb begin
        idx_d = scan_tick ? idx_q + SCAN_W'(1) : idx_q;
        case (idx_q)
            2'd0:    sel_digit = su_q;
            2'd1:    sel_digit = st_q;
            2'd2:    sel_digit = mu_q;
            default: sel_digit = mt_q;
        endcase
        seg_d = seg_decode(sel_digit);
    end

    // State, digit, done and display registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mt_q    <= '0;
            mu_q    <= '0;
            st_q    <= '0;
            su_q    <= '0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            seg_q   <= SEG_0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mu_q    <= mu_d;
            st_q    <= st_d;
            su_q    <= su_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
        end
    end

    assign an_scan = ~(4'b0001 << idx_q);
    assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSED);
    assign done    = done_q;
    assign seg     = seg_q;
    assign dp      = (idx_q != 2'd2);

`ifdef BREW_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;

    // Blink phase: restart visible on entry to FINISHED, toggle every BLINK_DIV seconds
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (state_q != ST_FINISHED || state_d != ST_FINISHED) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (sec_tick) begin
            if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Blink phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign an = blink_off_q ? 4'b1111 : an_scan;
`else
    assign an = an_scan;
`endif

endmodule
